bcd_convert_seq: RTL and testbench

- Multi-cycle, resource-shared binary-to-BCD converter controller for the 8-digit BCD multiplier datapath.
- Sequences one shift-add-3 (double-dabble) iteration per clock across a WIDTH-bit binary operand.
- Uses a single correction/shift datapath instead of an unrolled combinational network.
- Start/done handshake toward the multiplier result path; saturating overflow detection when the value exceeds DIGITS decimal digits.

---
 rtl/bcd_convert_seq_if.sv | 23 ++
 rtl/bcd_convert_seq.sv | 88 ++++++++
 tb/tb_bcd_convert_seq.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_convert_seq_if.sv
// Start/done handshake and result bus between the multiplier result path and
// the sequential binary-to-BCD converter.
interface bcd_convert_seq_if #(
  parameter int unsigned WIDTH  = 27,
  parameter int unsigned DIGITS = 8
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/bcd_convert_seq.sv
// Multi-cycle double-dabble binary-to-BCD converter: one add-3/shift iteration
// per clock through a single shared datapath, saturating on decimal overflow.
module bcd_convert_seq #(
  parameter int unsigned WIDTH  = 27,
  parameter int unsigned DIGITS = 8
) (
  input logic             clk,
  input logic             rst_n,
  bcd_convert_seq_if.slave bus
);

  localparam int unsigned SrW  = 4 * DIGITS + WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0]     LastCnt  = CntW'(WIDTH - 1);
  localparam logic [4*DIGITS-1:0] AllNines = {DIGITS{4'h9}};

  typedef enum logic {StIdle, StShift} state_t;

  state_t              state_q;
  logic [CntW-1:0]     count_q;
  logic [SrW-1:0]      sr_q;
  logic                ovf_sticky_q;
  logic                busy_q;
  logic                done_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic                ovf_q;

  logic [SrW-1:0]      corrected;
  logic [SrW-1:0]      shifted;
  logic                ovf_next;

  // Digits are corrected independently; the add-3 never carries into the next digit.
  always_comb begin
    corrected = sr_q;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (sr_q[WIDTH+4*d +: 4] >= 4'd5) begin
        corrected[WIDTH+4*d +: 4] = sr_q[WIDTH+4*d +: 4] + 4'd3;
      end
    end
    shifted  = {corrected[SrW-2:0], 1'b0};
    ovf_next = ovf_sticky_q | corrected[SrW-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      count_q      <= '0;
      sr_q         <= '0;
      ovf_sticky_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bcd_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            sr_q         <= {{(4*DIGITS){1'b0}}, bus.bin_in};
            count_q      <= '0;
            ovf_sticky_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= StShift;
          end
        end
        StShift: begin
          sr_q         <= shifted;
          ovf_sticky_q <= ovf_next;
          count_q      <= count_q + 1'b1;
          if (count_q == LastCnt) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= ovf_next ? AllNines : shifted[SrW-1 -: 4*DIGITS];
            ovf_q   <= ovf_next;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Randomised self-checking bench for bcd_convert_seq against a decimal arithmetic model.
module tb_bcd_convert_seq;

  localparam int unsigned WIDTH  = 27;
  localparam int unsigned DIGITS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  bcd_convert_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bcd_convert_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference: digit extraction by division, saturating above 10^DIGITS-1.
  function automatic void model(input longint unsigned v, output logic [4*DIGITS-1:0] bcd,
                                output logic ovf);
    longint unsigned maxv = 1;
    for (int i = 0; i < int'(DIGITS); i++) maxv = maxv * 10;
    maxv = maxv - 1;
    ovf = (v > maxv);
    bcd = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (ovf) begin
        bcd[4*i +: 4] = 4'd9;
      end else begin
        bcd[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
  endfunction

  task automatic start_conv(input longint unsigned v);
    bus.start  = 1'b1;
    bus.bin_in = WIDTH'(v);
    tick();
    bus.start  = 1'b0;
    bus.bin_in = WIDTH'($urandom);
  endtask

  task automatic wait_done(output int n, output int busy_cycles, output int overlap);
    n = 0;
    busy_cycles = 0;
    overlap = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.busy === 1'b1 && bus.done === 1'b1) overlap++;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    bus.start  = 1'b0;
    bus.bin_in = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== '0 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b bcd=%h ovf=%b required 0/0/0/0",
               bus.busy, bus.done, bus.bcd_out, bus.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero();
    int n, bc, ov;
    start_conv(0);
    wait_done(n, bc, ov);
    checks++;
    if (bc !== 27 || ov !== 0) begin
      failures++;
      $display("FAIL zero_busy: busy_cycles=%0d overlap=%0d required 27/0", bc, ov);
    end
    checks++;
    if (bus.bcd_out !== 32'h0 || bus.overflow !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_result: bcd=%h ovf=%b busy=%b required 00000000/0/0",
               bus.bcd_out, bus.overflow, bus.busy);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL zero_done_pulse: done=%b required 0", bus.done);
    end
  endtask

  task automatic test_known();
    int n, bc, ov;
    start_conv(12345678);
    wait_done(n, bc, ov);
    checks++;
    if (n !== 27) begin
      failures++;
      $display("FAIL known_latency: edges=%0d required 27", n);
    end
    checks++;
    if (bus.bcd_out !== 32'h12345678 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL known_result: bcd=%h ovf=%b required 12345678/0", bus.bcd_out, bus.overflow);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n1, n2, bc, ov;
    start_conv(99999999);
    wait_done(n1, bc, ov);
    checks++;
    if (bus.bcd_out !== 32'h99999999 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: bcd=%h ovf=%b required 99999999/0", bus.bcd_out, bus.overflow);
    end
    start_conv(100000000);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b done=%b required 1/0", bus.busy, bus.done);
    end
    wait_done(n2, bc, ov);
    checks++;
    if (n2 + 1 !== 28) begin
      failures++;
      $display("FAIL b2b_gap: done_gap=%0d required 28", n2 + 1);
    end
    checks++;
    if (bus.bcd_out !== 32'h99999999 || bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second: bcd=%h ovf=%b required 99999999/1", bus.bcd_out, bus.overflow);
    end
    tick();
  endtask

  task automatic test_all_ones();
    int n, bc, ov;
    start_conv(134217727);
    wait_done(n, bc, ov);
    checks++;
    if (bus.bcd_out !== 32'h99999999 || bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL all_ones: bcd=%h ovf=%b required 99999999/1", bus.bcd_out, bus.overflow);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int n, bc, ov, extra;
    start_conv(5678);
    for (int i = 0; i < 9; i++) tick();
    bus.start  = 1'b1;
    bus.bin_in = WIDTH'(1);
    tick();
    bus.start  = 1'b0;
    wait_done(n, bc, ov);
    checks++;
    if (n + 10 !== 27) begin
      failures++;
      $display("FAIL ignore_latency: edges=%0d required 27", n + 10);
    end
    checks++;
    if (bus.bcd_out !== 32'h00005678 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL ignore_result: bcd=%h ovf=%b required 00005678/0", bus.bcd_out, bus.overflow);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL ignore_single_done: extra_activity_cycles=%0d required 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int n, bc, ov, spurious;
    start_conv(4321);
    for (int i = 0; i < 11; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== '0 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs: busy=%b done=%b bcd=%h ovf=%b required 0/0/0/0",
               bus.busy, bus.done, bus.bcd_out, bus.overflow);
    end
    spurious = 0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      failures++;
      $display("FAIL abort_no_done: active_cycles=%0d required 0", spurious);
    end
    start_conv(7);
    wait_done(n, bc, ov);
    checks++;
    if (n !== 27 || bus.bcd_out !== 32'h00000007 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL abort_recover: edges=%0d bcd=%h ovf=%b required 27/00000007/0",
               n, bus.bcd_out, bus.overflow);
    end
    tick();
  endtask

  task automatic test_random();
    int n, bc, ov;
    longint unsigned v;
    logic [4*DIGITS-1:0] exp_bcd;
    logic exp_ovf;
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) v = 64'd99999990 + 64'($urandom_range(0, 20));
      else            v = 64'($urandom_range(0, 134217727));
      model(v, exp_bcd, exp_ovf);
      start_conv(v);
      wait_done(n, bc, ov);
      checks++;
      if (n !== 27 || ov !== 0 || bus.bcd_out !== exp_bcd || bus.overflow !== exp_ovf) begin
        failures++;
        $display("FAIL random_%0d: in=%0d edges=%0d overlap=%0d bcd=%h ovf=%b required 27/0/%h/%b",
                 i, v, n, ov, bus.bcd_out, bus.overflow, exp_bcd, exp_ovf);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_known();
    test_back_to_back();
    test_all_ones();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
